// File: rtl/ami_req_arbiter.sv
// ---------------------------------------------------------------------------
// ami_pkg / ami_req_arbiter
//
// Purpose: shares one AMI memory port between NUM_REQ requesters. A
// round-robin arbiter loads the winning request into a registered output
// stage that holds it until the shell accepts it. Read responses return in
// order, and an in-order tag FIFO routes each one back to the requester that
// issued the read. Writes produce no response.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   req_in[]        per-requester request (valid qualifies)
//   req_grant_out[] one-cycle pulse: request taken this cycle
//   mem_req         registered request toward the shell port
//   mem_req_grant   shell accepted mem_req this cycle
//   mem_resp        shell read response (valid qualifies)
//   mem_resp_grant  response consumed (routed or dropped) this cycle
//   resp_out[]      routed response; valid only for the head-tag requester
//   resp_grant_in[] requester consumed its resp_out
//   outstanding     reads issued to the shell but not yet returned
//   drop_count      saturating count of responses that arrived with no tag
// ---------------------------------------------------------------------------
package ami_pkg;
  typedef struct packed {
    logic         valid;
    logic         is_write;
    logic [63:0]  addr;
    logic [511:0] data;
    logic [63:0]  size;
  } AMIRequest;

  typedef struct packed {
    logic         valid;
    logic [511:0] data;
    logic [63:0]  size;
  } AMIResponse;
endpackage

module ami_req_arbiter
  import ami_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int REQ_ID_W        = $clog2(NUM_REQ),
  parameter int LOG_ORDER_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  AMIRequest                req_in        [NUM_REQ],
  output logic                     req_grant_out [NUM_REQ],
  output AMIRequest                mem_req,
  input  logic                     mem_req_grant,
  input  AMIResponse               mem_resp,
  output logic                     mem_resp_grant,
  output AMIResponse               resp_out      [NUM_REQ],
  input  logic                     resp_grant_in [NUM_REQ],
  output logic [LOG_ORDER_DEPTH:0] outstanding,
  output logic [15:0]              drop_count
);

  localparam int DEPTH = 1 << LOG_ORDER_DEPTH;
  localparam logic [LOG_ORDER_DEPTH:0] DEPTH_CNT = (LOG_ORDER_DEPTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                     state_r;
  AMIRequest                  mem_req_r;
  logic [REQ_ID_W-1:0]        rr_ptr_r;
  logic [REQ_ID_W-1:0]        pend_tag_r;
  logic [REQ_ID_W-1:0]        tag_mem_r [DEPTH];
  logic [LOG_ORDER_DEPTH-1:0] wr_ptr_r;
  logic [LOG_ORDER_DEPTH-1:0] rd_ptr_r;
  logic [LOG_ORDER_DEPTH:0]   count_r;
  logic [15:0]                drop_cnt_r;

  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                push_s;
  logic                pop_s;
  logic                drop_s;
  logic                read_room_s;
  logic                slot_free_s;
  logic                any_elig_s;
  logic                load_s;
  logic [NUM_REQ-1:0]  elig_s;
  logic [REQ_ID_W-1:0] win_s;
  logic [REQ_ID_W-1:0] next_ptr_s;
  logic [REQ_ID_W-1:0] head_s;

  assign fifo_full_s  = (count_r == DEPTH_CNT);
  assign fifo_empty_s = (count_r == {(LOG_ORDER_DEPTH + 1){1'b0}});
  assign head_s       = tag_mem_r[rd_ptr_r];
  // The tag of a read leaves the output stage only when the shell takes it.
  assign push_s       = (state_r == ST_FULL) & mem_req_grant & ~mem_req_r.is_write & ~fifo_full_s;
  assign slot_free_s  = (state_r == ST_EMPTY) | mem_req_grant;
  // A new read needs room even after the tag that is being pushed right now;
  // a same-cycle pop is deliberately not credited.
  assign read_room_s  = ((count_r + (LOG_ORDER_DEPTH + 1)'(push_s)) < DEPTH_CNT);
  assign load_s       = slot_free_s & any_elig_s;
  assign next_ptr_s   = (win_s == REQ_ID_W'(NUM_REQ - 1)) ? {REQ_ID_W{1'b0}} : (win_s + REQ_ID_W'(1));

  assign mem_req      = mem_req_r;
  assign outstanding  = count_r;
  assign drop_count   = drop_cnt_r;

  // Eligibility: writes only need valid; reads also need tag FIFO room.
  always_comb begin
    elig_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = req_in[i].valid & (req_in[i].is_write | read_room_s);
    end
  end

  // Round-robin pick: first eligible index at or after rr_ptr_r, wrapping.
  always_comb begin
    win_s      = {REQ_ID_W{1'b0}};
    any_elig_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr_r) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!any_elig_s && elig_s[idx]) begin
        any_elig_s = 1'b1;
        win_s      = REQ_ID_W'(idx);
      end else begin
        any_elig_s = any_elig_s;
      end
    end
  end

  // Grant pulse to the winner in the cycle its request is taken.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_grant_out[i] = load_s & (win_s == REQ_ID_W'(i));
    end
  end

  // Response fan-out: data goes to everyone, valid only to the head tag.
  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      resp_out[j]       = mem_resp;
      resp_out[j].valid = mem_resp.valid & ~fifo_empty_s & (head_s == REQ_ID_W'(j));
    end
  end

  // Response handshake: consume from the head requester, or drop if no tag.
  always_comb begin
    if (fifo_empty_s) begin
      mem_resp_grant = mem_resp.valid;
      pop_s          = 1'b0;
      drop_s         = mem_resp.valid;
    end else begin
      mem_resp_grant = mem_resp.valid & resp_grant_in[head_s];
      pop_s          = mem_resp.valid & resp_grant_in[head_s];
      drop_s         = 1'b0;
    end
  end

  // Output-stage FSM: latches the winner and holds it until the shell accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_EMPTY;
      mem_req_r  <= '0;
      rr_ptr_r   <= {REQ_ID_W{1'b0}};
      pend_tag_r <= {REQ_ID_W{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (load_s) begin
            state_r   <= ST_FULL;
            mem_req_r <= req_in[win_s];
            rr_ptr_r  <= next_ptr_s;
            if (!req_in[win_s].is_write) pend_tag_r <= win_s;
          end
        end
        ST_FULL: begin
          if (load_s) begin
            state_r   <= ST_FULL;
            mem_req_r <= req_in[win_s];
            rr_ptr_r  <= next_ptr_s;
            if (!req_in[win_s].is_write) pend_tag_r <= win_s;
          end else if (mem_req_grant) begin
            state_r         <= ST_EMPTY;
            mem_req_r.valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_EMPTY;
          mem_req_r <= '0;
        end
      endcase
    end
  end

  // In-order tag FIFO, outstanding-read count and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < DEPTH; d++) tag_mem_r[d] <= {REQ_ID_W{1'b0}};
      wr_ptr_r   <= {LOG_ORDER_DEPTH{1'b0}};
      rd_ptr_r   <= {LOG_ORDER_DEPTH{1'b0}};
      count_r    <= {(LOG_ORDER_DEPTH + 1){1'b0}};
      drop_cnt_r <= 16'h0000;
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= pend_tag_r;
        wr_ptr_r            <= wr_ptr_r + LOG_ORDER_DEPTH'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + LOG_ORDER_DEPTH'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (LOG_ORDER_DEPTH + 1)'(1);
        2'b01:   count_r <= count_r - (LOG_ORDER_DEPTH + 1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'h0001;
    end
  end

endmodule

// File: tb/tb_ami_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ami_req_arbiter
//
// Purpose: directed self-checking bench for ami_req_arbiter (NUM_REQ=4,
// 16-deep tag FIFO). Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_ami_req_arbiter;
  import ami_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  AMIRequest  req_in        [4];
  logic       req_grant_out [4];
  AMIRequest  mem_req;
  logic       mem_req_grant;
  AMIResponse mem_resp;
  logic       mem_resp_grant;
  AMIResponse resp_out      [4];
  logic       resp_grant_in [4];
  logic [4:0] outstanding;
  logic [15:0] drop_count;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  ami_req_arbiter #(
    .NUM_REQ        (4),
    .REQ_ID_W       (2),
    .LOG_ORDER_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_in        (req_in),
    .req_grant_out (req_grant_out),
    .mem_req       (mem_req),
    .mem_req_grant (mem_req_grant),
    .mem_resp      (mem_resp),
    .mem_resp_grant(mem_resp_grant),
    .resp_out      (resp_out),
    .resp_grant_in (resp_grant_in),
    .outstanding   (outstanding),
    .drop_count    (drop_count)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gvec();
    return {req_grant_out[3], req_grant_out[2], req_grant_out[1], req_grant_out[0]};
  endfunction

  function automatic logic [3:0] rvec();
    return {resp_out[3].valid, resp_out[2].valid, resp_out[1].valid, resp_out[0].valid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      req_in[i]        = '0;
      resp_grant_in[i] = 1'b0;
    end
    mem_req_grant = 1'b0;
    mem_resp      = '0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [63:0] addr);
    req_in[i].valid    = 1'b1;
    req_in[i].is_write = wr;
    req_in[i].addr     = addr;
    req_in[i].data     = {8{addr}};
    req_in[i].size     = 64'd64;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int loads;
    int pulses;
    int changes;
    AMIRequest snap;
    logic [63:0] exp_addr;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    clear_inputs();
    #2;
    check_eq("rst_mem_valid", 64'(mem_req.valid), 64'd0);
    check_eq("rst_mem_addr", mem_req.addr, 64'd0);
    check_eq("rst_outstanding", 64'(outstanding), 64'd0);
    check_eq("rst_drop", 64'(drop_count), 64'd0);
    check_eq("rst_grants", 64'(gvec()), 64'd0);
    check_eq("rst_resp_grant", 64'(mem_resp_grant), 64'd0);
    check_eq("rst_resp_valid", 64'(rvec()), 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // ---------------- single read from requester 2 ----------------
    step();
    set_req(2, 1'b0, 64'h1000);
    sample();
    check_eq("t1_grant", 64'(gvec()), 64'h4);
    step();
    req_in[2].valid = 1'b0;
    sample();
    check_eq("t1_mem_valid", 64'(mem_req.valid), 64'd1);
    check_eq("t1_mem_addr", mem_req.addr, 64'h1000);
    check_eq("t1_no_grant", 64'(gvec()), 64'd0);
    mem_req_grant = 1'b1;
    step();
    mem_req_grant = 1'b0;
    mem_resp.valid = 1'b1;
    mem_resp.data  = 512'hABCD;
    for (int i = 0; i < 4; i++) resp_grant_in[i] = 1'b1;
    sample();
    check_eq("t1_outstanding1", 64'(outstanding), 64'd1);
    check_eq("t1_mem_empty", 64'(mem_req.valid), 64'd0);
    check_eq("t1_resp_route", 64'(rvec()), 64'h4);
    check_eq("t1_resp_data", resp_out[2].data[63:0], 64'hABCD);
    check_eq("t1_resp_grant", 64'(mem_resp_grant), 64'd1);
    step();
    mem_resp.valid = 1'b0;
    sample();
    check_eq("t1_outstanding0", 64'(outstanding), 64'd0);
    check_eq("t1_resp_idle", 64'(rvec()), 64'd0);

    // ---------------- continuous reads, round robin ----------------
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 64'(64'h100 * (i + 1)));
    mem_req_grant = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample();
      check_eq($sformatf("t2_grant_%0d", k), 64'(gvec()), 64'(4'b0001 << (k % 4)));
      if (k >= 1) begin
        exp_addr = 64'(64'h100 * (((k - 1) % 4) + 1));
        check_eq($sformatf("t2_mem_valid_%0d", k), 64'(mem_req.valid), 64'd1);
        check_eq($sformatf("t2_mem_addr_%0d", k), mem_req.addr, exp_addr);
      end else begin
        check_eq("t2_mem_valid_first", 64'(mem_req.valid), 64'd0);
      end
      step();
    end
    for (int i = 0; i < 4; i++) req_in[i].valid = 1'b0;
    sample();
    check_eq("t2_last_addr", mem_req.addr, 64'h400);
    step();
    mem_req_grant = 1'b0;
    sample();
    check_eq("t2_outstanding", 64'(outstanding), 64'd8);

    // ---------------- shell backpressure ----------------
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 64'(64'h2000 + i));
    pulses  = 0;
    changes = 0;
    snap    = '0;
    for (int k = 0; k < 20; k++) begin
      sample();
      pulses += $countones(gvec());
      if (k == 1) snap = mem_req;
      if (k > 1 && mem_req !== snap) changes++;
      step();
    end
    check_eq("t3_pulses", 64'(pulses), 64'd1);
    check_eq("t3_changes", 64'(changes), 64'd0);
    check_eq("t3_mem_addr", mem_req.addr, 64'h2000);
    check_eq("t3_mem_valid", 64'(mem_req.valid), 64'd1);

    // ---------------- tag FIFO full ----------------
    do_reset();
    set_req(0, 1'b0, 64'h3000);
    mem_req_grant = 1'b1;
    loads = 0;
    for (int c = 0; c < 17; c++) begin
      sample();
      loads += int'(req_grant_out[0]);
      step();
    end
    sample();
    check_eq("t4_loads", 64'(loads), 64'd16);
    check_eq("t4_outstanding", 64'(outstanding), 64'd16);
    check_eq("t4_mem_empty", 64'(mem_req.valid), 64'd0);
    check_eq("t4_read_blocked", 64'(gvec()), 64'd0);
    step();
    req_in[0].valid = 1'b0;
    mem_req_grant   = 1'b0;
    set_req(1, 1'b0, 64'h3100);
    set_req(3, 1'b1, 64'h3300);
    sample();
    check_eq("t4_write_grant", 64'(gvec()), 64'h8);
    step();
    req_in[3].valid = 1'b0;
    mem_req_grant   = 1'b1;
    sample();
    check_eq("t4_read_still_blocked", 64'(gvec()), 64'd0);
    check_eq("t4_mem_is_write", 64'(mem_req.is_write), 64'd1);
    check_eq("t4_mem_write_addr", mem_req.addr, 64'h3300);
    step();
    mem_req_grant  = 1'b0;
    mem_resp.valid = 1'b1;
    mem_resp.data  = 512'h55;
    for (int i = 0; i < 4; i++) resp_grant_in[i] = 1'b1;
    sample();
    check_eq("t4_resp_route", 64'(rvec()), 64'h1);
    check_eq("t4_resp_grant", 64'(mem_resp_grant), 64'd1);
    check_eq("t4_no_grant_on_pop", 64'(gvec()), 64'd0);
    check_eq("t4_outstanding_full", 64'(outstanding), 64'd16);
    step();
    mem_resp.valid = 1'b0;
    sample();
    check_eq("t4_outstanding_pop", 64'(outstanding), 64'd15);
    check_eq("t4_read_unblocked", 64'(gvec()), 64'h2);
    step();
    req_in[1].valid = 1'b0;

    // ---------------- drop and response backpressure ----------------
    do_reset();
    mem_resp.valid = 1'b1;
    sample();
    check_eq("t5_drop_grant", 64'(mem_resp_grant), 64'd1);
    check_eq("t5_drop_no_route", 64'(rvec()), 64'd0);
    step();
    mem_resp.valid = 1'b0;
    sample();
    check_eq("t5_drop_count", 64'(drop_count), 64'd1);
    step();
    set_req(1, 1'b0, 64'h4100);
    sample();
    check_eq("t5_grant", 64'(gvec()), 64'h2);
    step();
    req_in[1].valid = 1'b0;
    mem_req_grant   = 1'b1;
    step();
    mem_req_grant  = 1'b0;
    mem_resp.valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      check_eq($sformatf("t5_hold_grant_%0d", k), 64'(mem_resp_grant), 64'd0);
      check_eq($sformatf("t5_hold_route_%0d", k), 64'(rvec()), 64'h2);
      step();
    end
    resp_grant_in[1] = 1'b1;
    sample();
    check_eq("t5_hold_outstanding", 64'(outstanding), 64'd1);
    check_eq("t5_release_grant", 64'(mem_resp_grant), 64'd1);
    step();
    mem_resp.valid   = 1'b0;
    resp_grant_in[1] = 1'b0;
    sample();
    check_eq("t5_outstanding0", 64'(outstanding), 64'd0);
    check_eq("t5_drop_unchanged", 64'(drop_count), 64'd1);

    // ---------------- reset mid-operation ----------------
    step();
    set_req(0, 1'b0, 64'h5000);
    mem_req_grant = 1'b1;
    for (int k = 0; k < 4; k++) step();
    req_in[0].valid = 1'b0;
    mem_req_grant   = 1'b0;
    sample();
    check_eq("t6_pre_outstanding", 64'(outstanding), 64'd3);
    check_eq("t6_pre_full", 64'(mem_req.valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_mem_valid", 64'(mem_req.valid), 64'd0);
    check_eq("t6_rst_mem_addr", mem_req.addr, 64'd0);
    check_eq("t6_rst_outstanding", 64'(outstanding), 64'd0);
    check_eq("t6_rst_drop", 64'(drop_count), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    mem_resp.valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      check_eq($sformatf("t6_late_grant_%0d", k), 64'(mem_resp_grant), 64'd1);
      check_eq($sformatf("t6_late_route_%0d", k), 64'(rvec()), 64'd0);
      step();
    end
    mem_resp.valid = 1'b0;
    sample();
    check_eq("t6_late_drops", 64'(drop_count), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
